// File: rtl/c_store_splitter.sv
// c_store_splitter
//   Takes one store from the LSU (byte, half or word at any byte address) and
//   issues aligned 32-bit write beats to data memory. A store that fits in one
//   word becomes one beat. A store that crosses a word boundary becomes two
//   beats: the low word first, then the high word.
//
//   Optional feature: define C_STORE_SPLIT_PERF_EN to build a counter of split
//   stores on split_cnt. Without the macro, split_cnt is tied to zero and the
//   datapath is unchanged.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   flush             kill request; only blocks acceptance while idle
//   st_valid/st_ready LSU store handshake (ready only while idle)
//   st_addr/size/wdata store operands (size 11 is illegal)
//   st_done           one-cycle pulse after the final beat is acknowledged
//   st_err            one-cycle pulse after an illegal-size store is taken
//   stall_lsu         high while a store is in progress
//   dmem_req/addr/wdata/sel/ack   write-beat interface, held until ack
//   split_cnt         number of completed split stores (perf build only)
module c_store_splitter #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_size,
  input  logic [31:0]       st_wdata,
  output logic              st_done,
  output logic              st_err,
  output logic              stall_lsu,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_sel,
  input  logic              dmem_ack,
  output logic [PERF_W-1:0] split_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t              state_reg;
  logic                dmem_req_reg;
  logic [ADDR_W-1:0]   dmem_addr_reg;
  logic [31:0]         dmem_wdata_reg;
  logic [3:0]          dmem_sel_reg;
  logic                st_done_reg;
  logic                st_err_reg;

  // Captured operands, so the LSU is free to change its inputs after accept.
  logic [1:0]          off_reg;
  logic [3:0]          mask_reg;
  logic [31:0]         wdata_reg;
  logic                cross_reg;

  logic                accept;
  logic [3:0]          in_mask;
  logic [2:0]          in_nbytes;
  logic                in_cross;
  logic [31:0]         beat0_wdata;
  logic [3:0]          beat0_sel;
  logic [2:0]          hi_shift;
  logic [31:0]         beat1_wdata;
  logic [3:0]          beat1_sel;

  assign st_ready  = (state_reg == IDLE);
  assign stall_lsu = (state_reg != IDLE);
  assign accept    = st_valid & st_ready & ~flush;

  always_comb begin
    in_mask   = 4'b1111;
    in_nbytes = 3'd4;
    case (st_size)
      2'b00: begin
        in_mask   = 4'b0001;
        in_nbytes = 3'd1;
      end
      2'b01: begin
        in_mask   = 4'b0011;
        in_nbytes = 3'd2;
      end
      default: begin
        in_mask   = 4'b1111;
        in_nbytes = 3'd4;
      end
    endcase
  end

  // off + nbytes never exceeds 7, so a 3-bit sum is enough.
  assign in_cross    = (({1'b0, st_addr[1:0]} + in_nbytes) > 3'd4);
  assign beat0_wdata = st_wdata << {st_addr[1:0], 3'b000};
  assign beat0_sel   = in_mask << st_addr[1:0];

  // The high beat only exists when off != 0, so the shift is 1..3 bytes.
  assign hi_shift    = 3'd4 - {1'b0, off_reg};
  assign beat1_wdata = wdata_reg >> {hi_shift, 3'b000};
  assign beat1_sel   = mask_reg >> hi_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      dmem_req_reg   <= 1'b0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= '0;
      dmem_sel_reg   <= '0;
      st_done_reg    <= 1'b0;
      st_err_reg     <= 1'b0;
      off_reg        <= '0;
      mask_reg       <= '0;
      wdata_reg      <= '0;
      cross_reg      <= 1'b0;
    end else begin
      st_done_reg <= 1'b0;
      st_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (st_size == 2'b11) begin
              st_err_reg <= 1'b1;
            end else begin
              state_reg      <= BEAT0;
              dmem_req_reg   <= 1'b1;
              dmem_addr_reg  <= {st_addr[ADDR_W-1:2], 2'b00};
              dmem_wdata_reg <= beat0_wdata;
              dmem_sel_reg   <= beat0_sel;
              off_reg        <= st_addr[1:0];
              mask_reg       <= in_mask;
              wdata_reg      <= st_wdata;
              cross_reg      <= in_cross;
            end
          end
        end
        BEAT0: begin
          if (dmem_ack) begin
            if (cross_reg) begin
              // Next word; the address wraps naturally at the top of memory.
              state_reg      <= BEAT1;
              dmem_addr_reg  <= dmem_addr_reg + ADDR_W'(4);
              dmem_wdata_reg <= beat1_wdata;
              dmem_sel_reg   <= beat1_sel;
            end else begin
              state_reg    <= IDLE;
              dmem_req_reg <= 1'b0;
              st_done_reg  <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (dmem_ack) begin
            state_reg    <= IDLE;
            dmem_req_reg <= 1'b0;
            st_done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          dmem_req_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef C_STORE_SPLIT_PERF_EN
  logic [PERF_W-1:0] split_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      split_cnt_reg <= '0;
    end else if ((state_reg == BEAT1) && dmem_ack) begin
      split_cnt_reg <= split_cnt_reg + PERF_W'(1);
    end
  end

  assign split_cnt = split_cnt_reg;
`else
  assign split_cnt = '0;
`endif

  assign dmem_req   = dmem_req_reg;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;
  assign dmem_sel   = dmem_sel_reg;
  assign st_done    = st_done_reg;
  assign st_err     = st_err_reg;

endmodule
